// File: rtl/logic_axi4_lite_pkg.sv
// Shared AXI4-Lite types: protection encoding, response codes, register-file
// channel FSM states and the protection check used by the register decoders.
package logic_axi4_lite_pkg;

  typedef enum logic {
    DATA_ACCESS        = 1'b0,
    INSTRUCTION_ACCESS = 1'b1
  } type_access_t;

  typedef enum logic {
    SECURE_ACCESS     = 1'b0,
    NON_SECURE_ACCESS = 1'b1
  } security_access_t;

  typedef enum logic {
    UNPRIVILEGED_ACCESS = 1'b0,
    PRIVILEGED_ACCESS   = 1'b1
  } privilege_access_t;

  // AxPROT[2:0] = {instruction, non-secure, privileged}
  typedef struct packed {
    type_access_t      type_access;
    security_access_t  security_access;
    privilege_access_t privilege_access;
  } access_t;

  typedef enum logic [1:0] {
    RESPONSE_OKAY   = 2'b00,
    RESPONSE_EXOKAY = 2'b01,
    RESPONSE_SLVERR = 2'b10,
    RESPONSE_DECERR = 2'b11
  } response_t;

  localparam access_t DEFAULT_DATA_ACCESS = '{
    type_access:      DATA_ACCESS,
    security_access:  SECURE_ACCESS,
    privilege_access: UNPRIVILEGED_ACCESS
  };

  typedef enum logic [1:0] {
    WRITE_IDLE,
    WRITE_WAIT_DATA,
    WRITE_WAIT_ADDR,
    WRITE_RESPONSE
  } write_state_t;

  typedef enum logic {
    READ_IDLE,
    READ_RESPONSE
  } read_state_t;

  // Protection check for one register; read-only handling is left to the caller.
  function automatic response_t check_access(access_t prot, logic privileged, logic secure);
    response_t response;
    response = RESPONSE_OKAY;
    if (prot.type_access == INSTRUCTION_ACCESS) begin
      response = RESPONSE_SLVERR;
    end else if (privileged && (prot.privilege_access == UNPRIVILEGED_ACCESS)) begin
      response = RESPONSE_SLVERR;
    end else if (secure && (prot.security_access == NON_SECURE_ACCESS)) begin
      response = RESPONSE_SLVERR;
    end
    return response;
  endfunction

endpackage

// File: rtl/logic_axi4_lite_register_decode.sv
// Combinational address/protection decoder for one AXI4-Lite channel.
// Ports: addr/prot/is_write in; index (register number) and response out.
// DECERR outranks SLVERR, which outranks OKAY.
module logic_axi4_lite_register_decode
  import logic_axi4_lite_pkg::*;
#(
  parameter int unsigned          DATA_BYTES      = 4,
  parameter int unsigned          ADDRESS_WIDTH   = 16,
  parameter int unsigned          REGISTERS       = 8,
  parameter int unsigned          BASE_ADDRESS    = 0,
  parameter int unsigned          INDEX_WIDTH     = 3,
  parameter logic [REGISTERS-1:0] READ_ONLY_MASK  = '0,
  parameter logic [REGISTERS-1:0] PRIVILEGED_MASK = '0,
  parameter logic [REGISTERS-1:0] SECURE_MASK     = '0
) (
  input  logic [ADDRESS_WIDTH-1:0] addr,
  input  access_t                  prot,
  input  logic                     is_write,
  output logic [INDEX_WIDTH-1:0]   index,
  output response_t                response
);

  localparam int unsigned BYTE_SHIFT = $clog2(DATA_BYTES);
  localparam logic [ADDRESS_WIDTH-1:0] BASE = ADDRESS_WIDTH'(BASE_ADDRESS);

  logic [ADDRESS_WIDTH:0]   diff;
  logic [ADDRESS_WIDTH-1:0] word;
  logic                     hit;
  logic                     privileged;
  logic                     secure;
  logic                     read_only;

  // Borrow out of the subtraction flags addresses below the base.
  always_comb begin
    diff       = {1'b0, addr} - {1'b0, BASE};
    word       = diff[ADDRESS_WIDTH-1:0] >> BYTE_SHIFT;
    hit        = 1'b0;
    privileged = 1'b0;
    secure     = 1'b0;
    read_only  = 1'b0;
    response   = RESPONSE_OKAY;
    if (!diff[ADDRESS_WIDTH]) begin
      for (int unsigned i = 0; i < REGISTERS; i++) begin
        if (word == ADDRESS_WIDTH'(i)) begin
          hit        = 1'b1;
          privileged = PRIVILEGED_MASK[i];
          secure     = SECURE_MASK[i];
          read_only  = READ_ONLY_MASK[i];
        end
      end
    end
    index = INDEX_WIDTH'(word);
    if (!hit) begin
      response = RESPONSE_DECERR;
    end else begin
      response = check_access(prot, privileged, secure);
      if ((response == RESPONSE_OKAY) && is_write && read_only) begin
        response = RESPONSE_SLVERR;
      end
    end
  end

endmodule

// File: rtl/logic_axi4_lite_register_file.sv
// AXI4-Lite slave exposing REGISTERS words of DATA_BYTES each.
// Ports: AXI4-Lite AW/W/B/AR/R channels on aclk/areset (async, active-high);
// registers_q exports RW contents, status_d feeds read-only registers,
// write_pulse/read_pulse strobe one cycle per committed write / OKAY read.
module logic_axi4_lite_register_file
  import logic_axi4_lite_pkg::*;
#(
  parameter int unsigned                        DATA_BYTES      = 4,
  parameter int unsigned                        ADDRESS_WIDTH   = 16,
  parameter int unsigned                        REGISTERS       = 8,
  parameter int unsigned                        BASE_ADDRESS    = 0,
  parameter logic [REGISTERS-1:0]               READ_ONLY_MASK  = '0,
  parameter logic [REGISTERS-1:0]               PRIVILEGED_MASK = '0,
  parameter logic [REGISTERS-1:0]               SECURE_MASK     = '0,
  parameter logic [REGISTERS*DATA_BYTES*8-1:0]  RESET_VALUES    = '0
) (
  input  logic                                aclk,
  input  logic                                areset,
  input  logic                                awvalid,
  output logic                                awready,
  input  logic [ADDRESS_WIDTH-1:0]            awaddr,
  input  access_t                             awprot,
  input  logic                                wvalid,
  output logic                                wready,
  input  logic [DATA_BYTES*8-1:0]             wdata,
  input  logic [DATA_BYTES-1:0]               wstrb,
  output logic                                bvalid,
  input  logic                                bready,
  output response_t                           bresp,
  input  logic                                arvalid,
  output logic                                arready,
  input  logic [ADDRESS_WIDTH-1:0]            araddr,
  input  access_t                             arprot,
  output logic                                rvalid,
  input  logic                                rready,
  output logic [DATA_BYTES*8-1:0]             rdata,
  output response_t                           rresp,
  output logic [REGISTERS*DATA_BYTES*8-1:0]   registers_q,
  input  logic [REGISTERS*DATA_BYTES*8-1:0]   status_d,
  output logic [REGISTERS-1:0]                write_pulse,
  output logic [REGISTERS-1:0]                read_pulse
);

  localparam int unsigned DATA_WIDTH  = DATA_BYTES * 8;
  localparam int unsigned INDEX_WIDTH = (REGISTERS > 1) ? $clog2(REGISTERS) : 1;

  logic [DATA_WIDTH-1:0] regs_q [REGISTERS];

  // ---------------- write channel ----------------
  write_state_t               wr_state, wr_state_d;
  logic                       awready_d, wready_d, bvalid_d;
  response_t                  bresp_d;
  logic [REGISTERS-1:0]       write_pulse_d;
  logic [ADDRESS_WIDTH-1:0]   aw_addr_q;
  access_t                    aw_prot_q;
  logic [DATA_WIDTH-1:0]      w_data_q;
  logic [DATA_BYTES-1:0]      w_strb_q;
  logic                       aw_capture, w_capture, wr_complete, wr_commit;
  logic                       aw_hs, w_hs;
  logic [ADDRESS_WIDTH-1:0]   wr_addr;
  access_t                    wr_prot;
  logic [DATA_WIDTH-1:0]      wr_data;
  logic [DATA_BYTES-1:0]      wr_strb;
  logic [INDEX_WIDTH-1:0]     wr_index;
  response_t                  wr_resp;

  assign aw_hs = awvalid && awready;
  assign w_hs  = wvalid && wready;

  // Whichever half arrived first comes from its capture register.
  always_comb begin
    wr_addr = (wr_state == WRITE_WAIT_DATA) ? aw_addr_q : awaddr;
    wr_prot = (wr_state == WRITE_WAIT_DATA) ? aw_prot_q : awprot;
    wr_data = (wr_state == WRITE_WAIT_ADDR) ? w_data_q  : wdata;
    wr_strb = (wr_state == WRITE_WAIT_ADDR) ? w_strb_q  : wstrb;
  end

  logic_axi4_lite_register_decode #(
    .DATA_BYTES      (DATA_BYTES),
    .ADDRESS_WIDTH   (ADDRESS_WIDTH),
    .REGISTERS       (REGISTERS),
    .BASE_ADDRESS    (BASE_ADDRESS),
    .INDEX_WIDTH     (INDEX_WIDTH),
    .READ_ONLY_MASK  (READ_ONLY_MASK),
    .PRIVILEGED_MASK (PRIVILEGED_MASK),
    .SECURE_MASK     (SECURE_MASK)
  ) u_write_decode (
    .addr     (wr_addr),
    .prot     (wr_prot),
    .is_write (1'b1),
    .index    (wr_index),
    .response (wr_resp)
  );

  // Write FSM next state and next registered outputs.
  always_comb begin
    wr_state_d    = wr_state;
    awready_d     = awready;
    wready_d      = wready;
    bvalid_d      = bvalid;
    bresp_d       = bresp;
    aw_capture    = 1'b0;
    w_capture     = 1'b0;
    wr_complete   = 1'b0;
    wr_commit     = 1'b0;
    write_pulse_d = '0;
    case (wr_state)
      WRITE_IDLE: begin
        if (aw_hs && w_hs) begin
          wr_complete = 1'b1;
        end else if (aw_hs) begin
          wr_state_d = WRITE_WAIT_DATA;
          awready_d  = 1'b0;
          aw_capture = 1'b1;
        end else if (w_hs) begin
          wr_state_d = WRITE_WAIT_ADDR;
          wready_d   = 1'b0;
          w_capture  = 1'b1;
        end
      end
      WRITE_WAIT_DATA: if (w_hs)  wr_complete = 1'b1;
      WRITE_WAIT_ADDR: if (aw_hs) wr_complete = 1'b1;
      WRITE_RESPONSE: begin
        if (bready) begin
          wr_state_d = WRITE_IDLE;
          bvalid_d   = 1'b0;
          awready_d  = 1'b1;
          wready_d   = 1'b1;
        end
      end
      default: wr_state_d = WRITE_IDLE;
    endcase
    if (wr_complete) begin
      wr_state_d = WRITE_RESPONSE;
      awready_d  = 1'b0;
      wready_d   = 1'b0;
      bvalid_d   = 1'b1;
      bresp_d    = wr_resp;
      wr_commit  = (wr_resp == RESPONSE_OKAY);
    end
    for (int unsigned i = 0; i < REGISTERS; i++) begin
      write_pulse_d[i] = wr_commit && (wr_index == INDEX_WIDTH'(i));
    end
  end

  // Write FSM state, handshake outputs and half-transaction capture.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      wr_state    <= WRITE_IDLE;
      awready     <= 1'b1;
      wready      <= 1'b1;
      bvalid      <= 1'b0;
      bresp       <= RESPONSE_OKAY;
      write_pulse <= '0;
      aw_addr_q   <= '0;
      aw_prot_q   <= DEFAULT_DATA_ACCESS;
      w_data_q    <= '0;
      w_strb_q    <= '0;
    end else begin
      wr_state    <= wr_state_d;
      awready     <= awready_d;
      wready      <= wready_d;
      bvalid      <= bvalid_d;
      bresp       <= bresp_d;
      write_pulse <= write_pulse_d;
      if (aw_capture) begin
        aw_addr_q <= awaddr;
        aw_prot_q <= awprot;
      end
      if (w_capture) begin
        w_data_q <= wdata;
        w_strb_q <= wstrb;
      end
    end
  end

  // Register storage with per-byte strobes; only OKAY writes commit.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      for (int unsigned i = 0; i < REGISTERS; i++) begin
        regs_q[i] <= RESET_VALUES[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end else if (wr_commit) begin
      for (int unsigned i = 0; i < REGISTERS; i++) begin
        if (wr_index == INDEX_WIDTH'(i)) begin
          for (int unsigned j = 0; j < DATA_BYTES; j++) begin
            if (wr_strb[j]) regs_q[i][j*8 +: 8] <= wr_data[j*8 +: 8];
          end
        end
      end
    end
  end

  for (genvar g = 0; g < REGISTERS; g++) begin : g_export
    assign registers_q[g*DATA_WIDTH +: DATA_WIDTH] = regs_q[g];
  end

  // ---------------- read channel ----------------
  read_state_t            rd_state, rd_state_d;
  logic                   arready_d, rvalid_d;
  logic [DATA_WIDTH-1:0]  rdata_d, rd_word;
  response_t              rresp_d, rd_resp;
  logic [REGISTERS-1:0]   read_pulse_d;
  logic [INDEX_WIDTH-1:0] rd_index;
  logic                   ar_hs;

  assign ar_hs = arvalid && arready;

  logic_axi4_lite_register_decode #(
    .DATA_BYTES      (DATA_BYTES),
    .ADDRESS_WIDTH   (ADDRESS_WIDTH),
    .REGISTERS       (REGISTERS),
    .BASE_ADDRESS    (BASE_ADDRESS),
    .INDEX_WIDTH     (INDEX_WIDTH),
    .READ_ONLY_MASK  (READ_ONLY_MASK),
    .PRIVILEGED_MASK (PRIVILEGED_MASK),
    .SECURE_MASK     (SECURE_MASK)
  ) u_read_decode (
    .addr     (araddr),
    .prot     (arprot),
    .is_write (1'b0),
    .index    (rd_index),
    .response (rd_resp)
  );

  // Read source: status input for read-only registers, storage otherwise.
  // Sampling regs_q here gives the pre-write value on a coincident commit.
  always_comb begin
    rd_word = '0;
    for (int unsigned i = 0; i < REGISTERS; i++) begin
      if (rd_index == INDEX_WIDTH'(i)) begin
        rd_word = READ_ONLY_MASK[i] ? status_d[i*DATA_WIDTH +: DATA_WIDTH] : regs_q[i];
      end
    end
  end

  // Read FSM next state and next registered outputs.
  always_comb begin
    rd_state_d   = rd_state;
    arready_d    = arready;
    rvalid_d     = rvalid;
    rdata_d      = rdata;
    rresp_d      = rresp;
    read_pulse_d = '0;
    case (rd_state)
      READ_IDLE: begin
        if (ar_hs) begin
          rd_state_d = READ_RESPONSE;
          arready_d  = 1'b0;
          rvalid_d   = 1'b1;
          rresp_d    = rd_resp;
          rdata_d    = (rd_resp == RESPONSE_OKAY) ? rd_word : '0;
          for (int unsigned i = 0; i < REGISTERS; i++) begin
            read_pulse_d[i] = (rd_resp == RESPONSE_OKAY) && (rd_index == INDEX_WIDTH'(i));
          end
        end
      end
      READ_RESPONSE: begin
        if (rready) begin
          rd_state_d = READ_IDLE;
          arready_d  = 1'b1;
          rvalid_d   = 1'b0;
        end
      end
      default: rd_state_d = READ_IDLE;
    endcase
  end

  // Read FSM state and registered outputs.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      rd_state   <= READ_IDLE;
      arready    <= 1'b1;
      rvalid     <= 1'b0;
      rdata      <= '0;
      rresp      <= RESPONSE_OKAY;
      read_pulse <= '0;
    end else begin
      rd_state   <= rd_state_d;
      arready    <= arready_d;
      rvalid     <= rvalid_d;
      rdata      <= rdata_d;
      rresp      <= rresp_d;
      read_pulse <= read_pulse_d;
    end
  end

endmodule

// File: tb/tb_logic_axi4_lite_register_file.sv
// Self-checking bench for logic_axi4_lite_register_file (8 x 32-bit registers).
module tb_logic_axi4_lite_register_file;

  localparam logic [7:0]   RO   = 8'b0001_0000;
  localparam logic [7:0]   PRIV = 8'b0000_1000;
  localparam logic [7:0]   SEC  = 8'b0010_0000;
  localparam logic [255:0] RV   = {32'h7700_0007, 32'h6600_0006, 32'h5500_0005, 32'h4444_4444,
                                   32'h3300_0003, 32'hCAFE_0001, 32'h0000_0000, 32'h1100_0000};
  localparam logic [1:0] OKAY = 2'b00, SLVERR = 2'b10, DECERR = 2'b11;

  logic         aclk, areset;
  logic         awvalid, awready, wvalid, wready, bvalid, bready;
  logic         arvalid, arready, rvalid, rready;
  logic [15:0]  awaddr, araddr;
  logic [2:0]   awprot, arprot;
  logic [31:0]  wdata, rdata;
  logic [3:0]   wstrb;
  logic [1:0]   bresp, rresp;
  logic [255:0] registers_q, status_d;
  logic [7:0]   write_pulse, read_pulse;

  typedef struct {
    logic [31:0] data;
    logic [1:0]  resp;
  } rd_exp_t;

  logic [1:0]  exp_b_q [$];
  rd_exp_t     exp_r_q [$];
  logic [31:0] model_regs [8];
  int          n_tests = 0;
  int          n_fail  = 0;

  logic_axi4_lite_register_file #(
    .DATA_BYTES      (4),
    .ADDRESS_WIDTH   (16),
    .REGISTERS       (8),
    .BASE_ADDRESS    (0),
    .READ_ONLY_MASK  (RO),
    .PRIVILEGED_MASK (PRIV),
    .SECURE_MASK     (SEC),
    .RESET_VALUES    (RV)
  ) dut (
    .aclk(aclk), .areset(areset),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awprot(awprot),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
    .bvalid(bvalid), .bready(bready), .bresp(bresp),
    .arvalid(arvalid), .arready(arready), .araddr(araddr), .arprot(arprot),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp),
    .registers_q(registers_q), .status_d(status_d),
    .write_pulse(write_pulse), .read_pulse(read_pulse)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [1:0] model_resp(input logic [15:0] addr, input logic [2:0] prot,
                                            input logic is_write);
    int idx;
    idx = int'(addr) / 4;
    if (idx >= 8) return DECERR;
    if (prot[2]) return SLVERR;
    if (PRIV[idx] && !prot[0]) return SLVERR;
    if (SEC[idx] && prot[1]) return SLVERR;
    if (is_write && RO[idx]) return SLVERR;
    return OKAY;
  endfunction

  function automatic logic [255:0] model_flat();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[i*32 +: 32] = model_regs[i];
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) model_regs[i] = RV[i*32 +: 32];
  endtask

  // gap > 0: AW leads W by gap cycles; gap < 0: W leads AW; hold = cycles bready stays low.
  task automatic do_write(input logic [15:0] addr, input logic [31:0] data, input logic [3:0] strb,
                          input logic [2:0] prot, input int gap, input int hold);
    logic [1:0] resp, exp;
    logic [7:0] exp_pulse;
    int idx, n;
    resp = model_resp(addr, prot, 1'b1);
    exp_b_q.push_back(resp);
    idx = int'(addr) / 4;
    exp_pulse = 8'h00;
    if (resp == OKAY) begin
      for (int j = 0; j < 4; j++) if (strb[j]) model_regs[idx][j*8 +: 8] = data[j*8 +: 8];
      exp_pulse = 8'(1) << idx;
    end
    if (gap >= 0) begin awvalid = 1'b1; awaddr = addr; awprot = prot; end
    if (gap <= 0) begin wvalid = 1'b1; wdata = data; wstrb = strb; end
    @(negedge aclk);
    if (gap > 0) begin
      awvalid = 1'b0;
      check("wait_data_awready", 256'(awready), 256'(0));
      check("wait_data_wready", 256'(wready), 256'(1));
      repeat (gap - 1) @(negedge aclk);
      wvalid = 1'b1; wdata = data; wstrb = strb;
      @(negedge aclk);
    end else if (gap < 0) begin
      wvalid = 1'b0;
      check("wait_addr_wready", 256'(wready), 256'(0));
      check("wait_addr_awready", 256'(awready), 256'(1));
      repeat (-gap - 1) @(negedge aclk);
      awvalid = 1'b1; awaddr = addr; awprot = prot;
      @(negedge aclk);
    end
    awvalid = 1'b0;
    wvalid  = 1'b0;
    n = 0;
    while (!bvalid && n < 16) begin @(negedge aclk); n++; end
    check("b_latency", 256'(n), 256'(0));
    check("write_pulse", 256'(write_pulse), 256'(exp_pulse));
    exp = exp_b_q.pop_front();
    check("bresp", 256'(bresp), 256'(exp));
    for (int h = 0; h < hold; h++) begin
      @(negedge aclk);
      check("b_hold_valid", 256'(bvalid), 256'(1));
      check("b_hold_resp", 256'(bresp), 256'(exp));
      check("b_hold_awready", 256'(awready), 256'(0));
      check("b_hold_pulse", 256'(write_pulse), 256'(0));
    end
    bready = 1'b1;
    @(negedge aclk);
    bready = 1'b0;
    check("bvalid_drop", 256'(bvalid), 256'(0));
    check("write_pulse_clear", 256'(write_pulse), 256'(0));
    check("awready_back", 256'(awready), 256'(1));
    if (idx < 8) check("reg_after_write", 256'(registers_q[idx*32 +: 32]), 256'(model_regs[idx]));
  endtask

  task automatic do_read(input logic [15:0] addr, input logic [2:0] prot, input int hold);
    rd_exp_t e;
    logic [7:0] exp_pulse;
    int idx, n;
    e.resp = model_resp(addr, prot, 1'b0);
    idx = int'(addr) / 4;
    e.data = 32'h0;
    exp_pulse = 8'h00;
    if (e.resp == OKAY) begin
      e.data = RO[idx] ? status_d[idx*32 +: 32] : model_regs[idx];
      exp_pulse = 8'(1) << idx;
    end
    exp_r_q.push_back(e);
    arvalid = 1'b1; araddr = addr; arprot = prot;
    @(negedge aclk);
    arvalid = 1'b0;
    n = 0;
    while (!rvalid && n < 16) begin @(negedge aclk); n++; end
    check("r_latency", 256'(n), 256'(0));
    check("read_pulse", 256'(read_pulse), 256'(exp_pulse));
    e = exp_r_q.pop_front();
    check("rdata", 256'(rdata), 256'(e.data));
    check("rresp", 256'(rresp), 256'(e.resp));
    for (int h = 0; h < hold; h++) begin
      @(negedge aclk);
      check("r_hold_valid", 256'(rvalid), 256'(1));
      check("r_hold_data", 256'(rdata), 256'(e.data));
      check("r_hold_resp", 256'(rresp), 256'(e.resp));
      check("r_hold_arready", 256'(arready), 256'(0));
    end
    rready = 1'b1;
    @(negedge aclk);
    rready = 1'b0;
    check("rvalid_drop", 256'(rvalid), 256'(0));
    check("read_pulse_clear", 256'(read_pulse), 256'(0));
    check("arready_back", 256'(arready), 256'(1));
  endtask

  initial begin
    rd_exp_t re;
    logic [1:0] be;
    areset = 1'b1;
    awvalid = 0; awaddr = 0; awprot = 0; wvalid = 0; wdata = 0; wstrb = 0; bready = 0;
    arvalid = 0; araddr = 0; arprot = 0; rready = 0;
    for (int i = 0; i < 8; i++) status_d[i*32 +: 32] = 32'hA5A5_0000 | 32'(i);
    status_d[4*32 +: 32] = 32'h0000_DEAD;
    model_reset();

    // Reset values while areset is held
    @(negedge aclk);
    check("rst_awready", 256'(awready), 256'(1));
    check("rst_wready", 256'(wready), 256'(1));
    check("rst_arready", 256'(arready), 256'(1));
    check("rst_bvalid", 256'(bvalid), 256'(0));
    check("rst_rvalid", 256'(rvalid), 256'(0));
    check("rst_bresp", 256'(bresp), 256'(OKAY));
    check("rst_rresp", 256'(rresp), 256'(OKAY));
    check("rst_rdata", 256'(rdata), 256'(0));
    check("rst_pulses", 256'({write_pulse, read_pulse}), 256'(0));
    check("rst_registers", registers_q, RV);
    areset = 1'b0;
    @(negedge aclk);

    do_read(16'h0008, 3'b000, 0);
    do_read(16'h0009, 3'b000, 0);
    do_write(16'h0004, 32'h1122_3344, 4'b0101, 3'b000, 3, 0);
    do_write(16'h0020, 32'hFFFF_FFFF, 4'b1111, 3'b000, 0, 0);
    do_read(16'h0020, 3'b000, 0);
    do_write(16'h000C, 32'h1234_5678, 4'b1111, 3'b000, 0, 0);
    do_write(16'h000C, 32'h1234_5678, 4'b1111, 3'b001, 0, 0);
    do_read(16'h000C, 3'b001, 0);
    do_read(16'h000C, 3'b000, 0);
    do_read(16'h0000, 3'b100, 0);
    do_read(16'h0010, 3'b000, 0);
    do_write(16'h0010, 32'hBEEF_0000, 4'b1111, 3'b000, 0, 0);
    do_write(16'h0014, 32'hAAAA_5555, 4'b0011, 3'b000, -2, 0);
    do_write(16'h0014, 32'h9999_9999, 4'b1111, 3'b010, -1, 0);
    do_write(16'h0000, 32'h0BAD_F00D, 4'b1010, 3'b000, 0, 5);
    do_read(16'h0000, 3'b000, 5);

    for (int k = 0; k < 24; k++) begin
      logic [15:0] a;
      logic [2:0]  p;
      a = 16'($urandom_range(0, 9) * 4 + $urandom_range(0, 3));
      p = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 1) == 1)
        do_write(a, $urandom, 4'($urandom_range(0, 15)), p,
                 int'($urandom_range(0, 4)) - 2, int'($urandom_range(0, 2)));
      else
        do_read(a, p, int'($urandom_range(0, 2)));
    end

    // Read and write of the same register on the same edge: read sees old value
    exp_r_q.push_back('{data: model_regs[6], resp: OKAY});
    exp_b_q.push_back(OKAY);
    model_regs[6] = 32'hFEED_BEEF;
    awvalid = 1'b1; awaddr = 16'h0018; awprot = 3'b000;
    wvalid = 1'b1; wdata = 32'hFEED_BEEF; wstrb = 4'hF;
    arvalid = 1'b1; araddr = 16'h0018; arprot = 3'b000;
    @(negedge aclk);
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    re = exp_r_q.pop_front();
    be = exp_b_q.pop_front();
    check("same_edge_rvalid", 256'(rvalid), 256'(1));
    check("same_edge_rdata", 256'(rdata), 256'(re.data));
    check("same_edge_bvalid", 256'(bvalid), 256'(1));
    check("same_edge_bresp", 256'(bresp), 256'(be));
    bready = 1'b1; rready = 1'b1;
    @(negedge aclk);
    bready = 1'b0; rready = 1'b0;
    do_read(16'h0018, 3'b000, 0);

    // Reset while the write FSM waits for data: nothing may commit
    awvalid = 1'b1; awaddr = 16'h0004; awprot = 3'b000;
    @(negedge aclk);
    awvalid = 1'b0;
    check("pre_rst_awready", 256'(awready), 256'(0));
    wvalid = 1'b1; wdata = 32'h9999_9999; wstrb = 4'hF;
    areset = 1'b1;
    model_reset();
    #1;
    check("async_rst_awready", 256'(awready), 256'(1));
    check("async_rst_registers", registers_q, RV);
    @(negedge aclk);
    wvalid = 1'b0;
    areset = 1'b0;
    @(negedge aclk);
    check("post_rst_bvalid", 256'(bvalid), 256'(0));
    check("post_rst_pulse", 256'(write_pulse), 256'(0));
    check("post_rst_wready", 256'(wready), 256'(1));
    check("post_rst_registers", registers_q, RV);
    do_read(16'h0004, 3'b000, 0);
    do_write(16'h001C, 32'h0102_0304, 4'b1100, 3'b000, 1, 1);

    check("final_registers", registers_q, model_flat());
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
